// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file arbiter.
package rf_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = IW'((int'(ptr) + i) % int'(N));
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_arbiter.sv
// Round-robin arbiter with bounded lock sharing one single-port register file,
// plus a two-stage registered read-response path back to the owning requester.
module rf_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned RF_ADDR_WIDTH = 3,
  parameter int unsigned RF_DATA_WIDTH = 4,
  parameter int unsigned MAX_LOCK      = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0]                 req_lock_i,
  input  logic [NUM_REQ-1:0]                 req_we_i,
  input  logic [NUM_REQ*RF_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*RF_DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic [RF_DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                               rf_en_o,
  output logic                               rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]           rf_addr_o,
  output logic [RF_DATA_WIDTH-1:0]           rf_data_o,
  input  logic [RF_DATA_WIDTH-1:0]           rf_data_i
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  state_e           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    owner;
  logic [CW-1:0]    lock_cnt;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    win_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic [NUM_REQ-1:0] ready;
  logic             accept;
  logic             s1_valid;
  logic             s1_read;
  logic [IW-1:0]    s1_id;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // While locked only the owner may be granted, even when it is idle.
  always_comb begin
    ready   = '0;
    win_idx = pick_idx;
    if (state == LOCKED) begin
      win_idx = owner;
      if (req_valid_i[owner]) ready[owner] = 1'b1;
    end else begin
      ready = pick_grant;
    end
  end

  assign req_ready_o = ready;
  assign accept      = |(req_valid_i & ready);

  always_comb begin
    rf_en_o   = accept;
    rf_we_o   = 1'b0;
    rf_addr_o = '0;
    rf_data_o = '0;
    if (accept) begin
      rf_we_o   = req_we_i[win_idx];
      rf_addr_o = req_addr_i[32'(win_idx)*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
      rf_data_o = req_wdata_i[32'(win_idx)*RF_DATA_WIDTH +: RF_DATA_WIDTH];
    end
  end

  // Arbitration state: pointer, lock owner and remaining lock budget.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (accept) begin
            rr_ptr <= wrap_inc(win_idx);
            if (req_lock_i[win_idx] && MAX_LOCK > 1) begin
              state    <= LOCKED;
              owner    <= win_idx;
              lock_cnt <= CW'(MAX_LOCK - 1);
            end
          end
        end
        LOCKED: begin
          if (accept) begin
            lock_cnt <= lock_cnt - 1'b1;
            if (!req_lock_i[owner] || lock_cnt == CW'(1)) begin
              state  <= ARB;
              rr_ptr <= wrap_inc(owner);
            end
          end else if (!req_valid_i[owner] && !req_lock_i[owner]) begin
            state  <= ARB;
            rr_ptr <= wrap_inc(owner);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // RF read data arrives one cycle after the strobe; response is registered on it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      s1_read     <= 1'b0;
      s1_id       <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      s1_valid    <= accept;
      s1_read     <= accept & ~req_we_i[win_idx];
      s1_id       <= win_idx;
      rsp_valid_o <= '0;
      if (s1_valid) begin
        rsp_valid_o[s1_id] <= 1'b1;
        rsp_rdata_o        <= s1_read ? rf_data_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed self-checking bench for rf_arbiter with default parameters.
module tb_rf_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  logic [1:0] req_lock_i;
  logic [1:0] req_we_i;
  logic [5:0] req_addr_i;
  logic [7:0] req_wdata_i;
  logic [1:0] rsp_valid_o;
  logic [3:0] rsp_rdata_o;
  logic       rf_en_o;
  logic       rf_we_o;
  logic [2:0] rf_addr_o;
  logic [3:0] rf_data_o;
  logic [3:0] rf_data_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  rf_arbiter u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_lock_i  (req_lock_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rf_en_o     (rf_en_o),
    .rf_we_o     (rf_we_o),
    .rf_addr_o   (rf_addr_o),
    .rf_data_o   (rf_data_o),
    .rf_data_i   (rf_data_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_lock_i  = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rf_data_i   = '0;
    tick();
    mid();
    check("rst_ready", 32'(req_ready_o), 0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata_o), 0);
    check("rst_rf_en", 32'(rf_en_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Single read by requester 0.
    req_valid_i = 2'b01; req_we_i = 2'b00; req_addr_i = {3'd0, 3'd5};
    mid();
    check("t1_ready", 32'(req_ready_o), 32'h1);
    check("t1_rf_en", 32'(rf_en_o), 1);
    check("t1_rf_we", 32'(rf_we_o), 0);
    check("t1_rf_addr", 32'(rf_addr_o), 5);
    tick();
    req_valid_i = '0; rf_data_i = 4'hA;
    mid();
    check("t1_rsp_early", 32'(rsp_valid_o), 0);
    check("t1_idle_en", 32'(rf_en_o), 0);
    tick();
    rf_data_i = 4'h0;
    mid();
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("t1_rsp_rdata", 32'(rsp_rdata_o), 32'hA);
    tick();
    mid();
    check("t1_rsp_clear", 32'(rsp_valid_o), 0);
    check("t1_rdata_hold", 32'(rsp_rdata_o), 32'hA);
    tick();

    // Write by requester 1 (pointer is now 1, returns to 0 afterwards).
    req_valid_i = 2'b10; req_we_i = 2'b10; req_addr_i = {3'd3, 3'd0}; req_wdata_i = {4'h7, 4'h0};
    mid();
    check("t3_ready", 32'(req_ready_o), 32'h2);
    check("t3_rf_we", 32'(rf_we_o), 1);
    check("t3_rf_addr", 32'(rf_addr_o), 3);
    check("t3_rf_data", 32'(rf_data_o), 7);
    tick();
    req_valid_i = '0; req_we_i = '0; req_wdata_i = '0; rf_data_i = 4'hF;
    tick();
    rf_data_i = 4'h0;
    mid();
    check("t3_rsp_valid", 32'(rsp_valid_o), 32'h2);
    check("t3_rsp_rdata", 32'(rsp_rdata_o), 0);
    tick();

    // Both requesting, no lock: grants and responses alternate 0,1,0,1.
    req_addr_i = {3'd2, 3'd1};
    for (int c = 0; c < 6; c++) begin
      req_valid_i = (c < 4) ? 2'b11 : 2'b00;
      rf_data_i   = (c >= 1 && c <= 4) ? 4'(8 + c - 1) : 4'h0;
      mid();
      if (c < 4) begin
        check($sformatf("t2_ready%0d", c), 32'(req_ready_o), (c % 2 == 0) ? 32'h1 : 32'h2);
        check($sformatf("t2_addr%0d", c), 32'(rf_addr_o), (c % 2 == 0) ? 32'h1 : 32'h2);
      end
      if (c >= 2) begin
        check($sformatf("t2_rsp%0d", c), 32'(rsp_valid_o), (c % 2 == 0) ? 32'h1 : 32'h2);
        check($sformatf("t2_rdata%0d", c), 32'(rsp_rdata_o), 32'(8 + c - 2));
      end else begin
        check($sformatf("t2_rsp%0d", c), 32'(rsp_valid_o), 0);
      end
      tick();
    end
    rf_data_i = '0;

    // Requester 0 locks with requester 1 waiting: budget of 4, then requester 1, then relock.
    req_valid_i = 2'b11; req_lock_i = 2'b01;
    for (int c = 0; c < 8; c++) begin
      mid();
      check($sformatf("t4_ready%0d", c), 32'(req_ready_o), (c == 4) ? 32'h2 : 32'h1);
      tick();
    end
    req_valid_i = 2'b00; req_lock_i = 2'b00;
    mid();
    check("t4_release", 32'(req_ready_o), 0);
    tick();

    // Lock, then release without access: requester 1 wins next cycle.
    req_valid_i = 2'b01; req_lock_i = 2'b01;
    mid();
    check("t5_lock", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 2'b10; req_lock_i = 2'b00;
    mid();
    check("t5_drop", 32'(req_ready_o), 0);
    tick();
    mid();
    check("t5_r1_grant", 32'(req_ready_o), 32'h2);
    tick();
    // Lock held while owner idle: requester 1 starves.
    req_valid_i = 2'b01; req_lock_i = 2'b01;
    mid();
    check("t5_lock2", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 2'b10;
    for (int c = 0; c < 3; c++) begin
      mid();
      check($sformatf("t5_held%0d", c), 32'(req_ready_o), 0);
      tick();
    end
    req_valid_i = 2'b00; req_lock_i = 2'b00;
    tick();

    // Reset between acceptance and response, with requester 1 holding a lock.
    req_valid_i = 2'b10; req_lock_i = 2'b10; req_we_i = 2'b00;
    mid();
    check("t6_accept", 32'(req_ready_o), 32'h2);
    tick();
    req_valid_i = 2'b00; rf_data_i = 4'h9;
    #1;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_rsp", 32'(rsp_valid_o), 0);
    check("t6_rst_rdata", 32'(rsp_rdata_o), 0);
    check("t6_rst_en", 32'(rf_en_o), 0);
    tick();
    rst_ni = 1'b1; req_lock_i = 2'b00; rf_data_i = '0;
    mid();
    check("t6_post_rsp", 32'(rsp_valid_o), 0);
    tick();
    req_valid_i = 2'b11;
    mid();
    check("t6_first_grant", 32'(req_ready_o), 32'h1);
    check("t6_no_rsp", 32'(rsp_valid_o), 0);
    tick();
    req_valid_i = 2'b00;
    mid();
    check("t6_rsp_wait", 32'(rsp_valid_o), 0);
    tick();
    mid();
    check("t6_rsp_new", 32'(rsp_valid_o), 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
- Shares the single-port 3-bit-address / 4-bit-data control register file between NUM_REQ requesters, for example the UART command bridge and the SPI debug port.
- Arbitrates round-robin with an optional bounded lock for multi-access sequences.
- Drives the RF enable, write-enable, address and data lines.
- Routes RF read data back to the owning requester as a registered response.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- RF_ADDR_WIDTH, 3, RF address width.
- RF_DATA_WIDTH, 4, RF data width.
- MAX_LOCK, 4, maximum consecutive accepted accesses one locked owner may make (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester access request.
- req_ready_o  out  NUM_REQ  per-requester grant; access accepted when valid&ready.
- req_lock_i  in  NUM_REQ  requester asks to keep ownership after this access.
- req_we_i  in  NUM_REQ  1=write, 0=read.
- req_addr_i  in  NUM_REQ*RF_ADDR_WIDTH  packed addresses, requester i at [i*W +: W].
- req_wdata_i  in  NUM_REQ*RF_DATA_WIDTH  packed write data.
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse to the owning requester.
- rsp_rdata_o  out  RF_DATA_WIDTH  response data, shared by all requesters.
- rf_en_o  out  1  RF access strobe.
- rf_we_o  out  1  RF write enable.
- rf_addr_o  out  RF_ADDR_WIDTH  RF address.
- rf_data_o  out  RF_DATA_WIDTH  RF write data.
- rf_data_i  in  RF_DATA_WIDTH  RF read data, valid the cycle after a read strobe.

Behaviour:

Reset and handshake
- Reset (async assert, sync release): state=ARB, rr_ptr=0, lock_cnt=0, owner=0, pipeline valids=0, rsp_valid_o=0, rsp_rdata_o=0.
- req_ready_o and rf_* outputs are combinational from state plus req_valid_i.
- At most one req_ready_o bit is high per cycle, and only for a requester with valid high. No request → all zero.
- A requester holds valid, we, addr, wdata and lock stable until accepted. Deasserting valid before acceptance is legal and withdraws the request.
- rf_en_o = |(req_valid_i & req_ready_o). rf_we_o, rf_addr_o and rf_data_o are muxed from the winner when rf_en_o is high, and 0 otherwise.
- Throughput: one access per cycle.

States
- ARB: winner = first valid requester at or after rr_ptr (index wraps). On acceptance, rr_ptr = winner+1 mod NUM_REQ.
  - If req_lock_i[winner]=1 and MAX_LOCK>1: go to LOCKED, owner=winner, lock_cnt=MAX_LOCK-1.
- LOCKED: only the owner can be granted. Other requesters see ready=0, even if the owner is idle. On each owner acceptance, lock_cnt decrements.
- LOCKED → ARB when any of the following holds:
  - owner accepted with lock=0;
  - owner accepted with lock_cnt==1 (budget exhausted, lock ignored);
  - owner valid=0 and lock=0 in any cycle (release without access).
  - The first ARB cycle starts at rr_ptr = owner+1, so a continuously-requesting owner cannot win it back first.

Response pipeline
- Acceptance in cycle T sets s1_valid, s1_id and s1_read.
- In cycle T+1 the pipeline registers rf_data_i if s1_read, else 0.
- In cycle T+2: rsp_valid_o[s1_id]=1 and rsp_rdata_o holds the captured data. Writes also get a response with data 0.
- rsp_rdata_o holds its value between pulses.
- Fully pipelined: back-to-back accepts give back-to-back responses, in order.

Boundary conditions
- Simultaneous requests are resolved by rr_ptr only.
- Reset mid-operation: in-flight responses are discarded and the lock is dropped.

Decomposition:
- Package rf_arb_pkg holds:
  - state_e {ARB, LOCKED};
  - function idx_w(n) = max(1, $clog2(n)).
- Sub-module rr_pick (combinational): inputs req vector and pointer; outputs one-hot grant and index. Instantiated once.

Test Plan:
1. Idle, then req 0 reads addr 5 with RF returning 4'hA → rf_en_o=1, rf_we_o=0, rf_addr_o=5 in T; rsp_valid_o=2'b01 and rsp_rdata_o=4'hA in T+2.
2. Both requesters valid every cycle, no lock, rr_ptr=0 → grants alternate 0,1,0,1; responses alternate in the same order, each 2 cycles after its grant.
3. Req 1 writes addr 3 data 4'h7 → rf_we_o=1, rf_data_o=7; rsp_valid_o[1] in T+2 with rsp_rdata_o=0.
4. Req 0 holds lock=1 and valid=1 for 8 cycles with req 1 also valid, MAX_LOCK=4 → req 0 granted 4 consecutive cycles, then req 1 granted.
5. Req 0 locks, then drops valid and lock while req 1 is waiting → req 1 granted the next cycle. With valid=0 and lock=1 instead, req 1 stays ungranted.
6. Assert rst_ni low between acceptance and response → outputs clear immediately, no rsp_valid_o after release, and the first grant after release goes to req 0.
